fmul_pipe: RTL

//  - Pipelined IEEE-754 single-precision multiplier, z = x * y, for the FPU datapath.
//  - Companion to fdiv: same x/y/z operand convention, but fully pipelined with a valid/stall handshake.
//  - Throughput is one result per cycle.
//  - Feeds the FPU writeback mux.
//  - Doubles as the golden multiply path for fdiv result checking (z*y ~ x).

---
 rtl/fmul_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single-precision multiplier, z = x * y.
// Stage 0 registers the operands. Stage 1 classifies them and forms the
// exponent sum and the 48-bit significand product. Stage 2 normalizes.
// Stage 3 rounds to nearest even and packs the result into z.
// A high stall freezes every register, and operands presented during a stall
// are dropped. Denormal inputs and outputs are flushed to zero.
module fmul_pipe #(
   parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] z
);

   localparam int STAGES = 3;

   logic                en;
   logic [STAGES:0]     vld_pipe_q;

   // stage 0: captured operands
   logic [31:0]         x_q, y_q;

   // stage 1: classification, exponent sum, raw product
   logic                s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
   logic signed [9:0]   s1_exp_d;
   logic [47:0]         s1_prod_d;
   logic                s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
   logic signed [9:0]   s1_exp_q;
   logic [47:0]         s1_prod_q;

   // stage 2: normalized mantissa plus guard/sticky
   logic [22:0]         s2_man_d;
   logic                s2_grd_d, s2_stk_d;
   logic signed [9:0]   s2_exp_d;
   logic [22:0]         s2_man_q;
   logic                s2_grd_q, s2_stk_q;
   logic signed [9:0]   s2_exp_q;
   logic                s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;

   // stage 3: rounding and pack
   logic [23:0]         rnd_man;
   logic                rnd_inc;
   logic signed [9:0]   rnd_exp;
   logic [31:0]         z_d, z_q;

   assign en        = ~stall;
   assign out_valid = vld_pipe_q[STAGES];
   assign z         = z_q;

   // valid shift register; a bubble enters whenever in_valid is low
   always_ff @(posedge clk) begin
      if (rst)     vld_pipe_q <= '0;
      else if (en) vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
   end

   // stage 0: capture the operands only when a new operation is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (en && in_valid) begin
         x_q <= x;
         y_q <= y;
      end
   end

   // stage 1 logic: classify operands, sum the exponents, multiply the significands
   always_comb begin
      logic [7:0]  xe, ye;
      logic [22:0] xm, ym;
      logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
      xe        = x_q[30:23];
      ye        = y_q[30:23];
      xm        = x_q[22:0];
      ym        = y_q[22:0];
      x_zero    = (xe == 8'h00);
      y_zero    = (ye == 8'h00);
      x_inf     = (xe == 8'hFF) && (xm == '0);
      y_inf     = (ye == 8'hFF) && (ym == '0);
      x_nan     = (xe == 8'hFF) && (xm != '0);
      y_nan     = (ye == 8'hFF) && (ym != '0);
      s1_sign_d = x_q[31] ^ y_q[31];
      // 0*Inf has no meaningful value, so it is reported as NaN
      s1_nan_d  = x_nan | y_nan | (x_zero & y_inf) | (x_inf & y_zero);
      s1_inf_d  = x_inf | y_inf;
      s1_zero_d = x_zero | y_zero;
      s1_exp_d  = $signed({2'b00, xe}) + $signed({2'b00, ye}) - 10'sd127;
      s1_prod_d = {24'd0, 1'b1, xm} * {24'd0, 1'b1, ym};
   end

   // stage 1 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_sign_q <= 1'b0;
         s1_nan_q  <= 1'b0;
         s1_inf_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_prod_q <= '0;
      end else if (en) begin
         s1_sign_q <= s1_sign_d;
         s1_nan_q  <= s1_nan_d;
         s1_inf_q  <= s1_inf_d;
         s1_zero_q <= s1_zero_d;
         s1_exp_q  <= s1_exp_d;
         s1_prod_q <= s1_prod_d;
      end
   end

   // stage 2 logic: the product of two [1,2) significands lies in [1,4),
   // so at most one right shift is needed
   always_comb begin
      if (s1_prod_q[47]) begin
         s2_man_d = s1_prod_q[46:24];
         s2_grd_d = s1_prod_q[23];
         s2_stk_d = |s1_prod_q[22:0];
         s2_exp_d = s1_exp_q + 10'sd1;
      end else begin
         s2_man_d = s1_prod_q[45:23];
         s2_grd_d = s1_prod_q[22];
         s2_stk_d = |s1_prod_q[21:0];
         s2_exp_d = s1_exp_q;
      end
   end

   // stage 2 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_man_q  <= '0;
         s2_grd_q  <= 1'b0;
         s2_stk_q  <= 1'b0;
         s2_exp_q  <= '0;
         s2_sign_q <= 1'b0;
         s2_nan_q  <= 1'b0;
         s2_inf_q  <= 1'b0;
         s2_zero_q <= 1'b0;
      end else if (en) begin
         s2_man_q  <= s2_man_d;
         s2_grd_q  <= s2_grd_d;
         s2_stk_q  <= s2_stk_d;
         s2_exp_q  <= s2_exp_d;
         s2_sign_q <= s1_sign_q;
         s2_nan_q  <= s1_nan_q;
         s2_inf_q  <= s1_inf_q;
         s2_zero_q <= s1_zero_q;
      end
   end

   // stage 3 logic: round to nearest even, then apply specials and range limits.
   // A mantissa carry-out happens only when the mantissa is all ones, so the
   // wrapped low bits are already zero.
   always_comb begin
      rnd_inc = s2_grd_q & (s2_stk_q | s2_man_q[0]);
      rnd_man = {1'b0, s2_man_q} + {23'd0, rnd_inc};
      rnd_exp = s2_exp_q + $signed({9'd0, rnd_man[23]});
      z_d     = z_q;
      if (vld_pipe_q[STAGES-1]) begin
         if (s2_nan_q)                z_d = NAN_OUT;
         else if (s2_inf_q)           z_d = {s2_sign_q, 8'hFF, 23'd0};
         else if (s2_zero_q)          z_d = {s2_sign_q, 31'd0};
         else if (rnd_exp >= 10'sd255) z_d = {s2_sign_q, 8'hFF, 23'd0};
         else if (rnd_exp <= 10'sd0)  z_d = {s2_sign_q, 31'd0};
         else                         z_d = {s2_sign_q, rnd_exp[7:0], rnd_man[22:0]};
      end
   end

   // output register: z holds its last value across bubbles
   always_ff @(posedge clk) begin
      if (rst)     z_q <= '0;
      else if (en) z_q <= z_d;
   end

endmodule
